// File: rtl/quad_pkg.sv
// Shared types and constants for the quadrature decoder.
package quad_pkg;

  typedef enum logic {
    INIT,
    TRACK
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] ph_next_fwd(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] ph_next_rev(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// Encoder inputs and step-pulse outputs of the quadrature decoder.
interface quad_decoder_if;
  logic       enc_a;
  logic       enc_b;
  logic       en;
  logic       up;
  logic       down;
  logic       err;
  logic [1:0] phase;

  modport master (output enc_a, enc_b, en, input up, down, err, phase);
  modport slave  (input enc_a, enc_b, en, output up, down, err, phase);
endinterface

// File: rtl/quad_glitch_filter.sv
// Per-channel debounce: output follows input only after FILTER_LEN
// consecutive cycles of disagreement; i_load forces an immediate copy.
module quad_glitch_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_d,
  output logic o_q
);

  logic       r_q;
  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q   <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_q   <= i_d;
      r_cnt <= '0;
    end else if (i_d != r_q) begin
      if (r_cnt == 4'(FILTER_LEN - 1)) begin
        r_q   <= i_d;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else begin
      r_cnt <= '0;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B and emits up/down/err step pulses.
// Define QUAD_FILTER_EN to insert per-channel glitch filters.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 4
) (
  input logic           clk,
  input logic           reset,
  quad_decoder_if.slave bus
);

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_len
    $error("quad_decoder: FILTER_LEN out of range 2..15");
  end

  logic [1:0] r_sa;
  logic [1:0] r_sb;
  logic [2:0] r_vld;
  logic [1:0] r_prev;
  logic       r_up;
  logic       r_down;
  logic       r_err;
  state_t     r_state;

  logic [1:0] w_sync;
  logic [1:0] w_acc;
  logic       w_prime;

  assign w_sync  = {r_sa[1], r_sb[1]};
  // Until the synchronizers hold real samples, previous state is reloaded
  // rather than compared, so a transition cut by reset never pulses.
  assign w_prime = ~r_vld[2];

`ifdef QUAD_FILTER_EN
  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .i_clk (clk),
    .i_rst (reset),
    .i_load(w_prime),
    .i_d   (w_sync[1]),
    .o_q   (w_acc[1])
  );

  quad_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .i_clk (clk),
    .i_rst (reset),
    .i_load(w_prime),
    .i_d   (w_sync[0]),
    .o_q   (w_acc[0])
  );
`else
  assign w_acc = w_sync;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa    <= '0;
      r_sb    <= '0;
      r_vld   <= '0;
      r_prev  <= PH_00;
      r_up    <= 1'b0;
      r_down  <= 1'b0;
      r_err   <= 1'b0;
      r_state <= INIT;
    end else begin
      r_sa   <= {r_sa[0], bus.enc_a};
      r_sb   <= {r_sb[0], bus.enc_b};
      r_vld  <= {r_vld[1:0], 1'b1};
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        INIT: begin
          r_prev  <= w_sync;
          r_state <= TRACK;
        end
        TRACK: begin
          if (w_prime) begin
            r_prev <= w_sync;
          end else if (w_acc != r_prev) begin
            r_prev <= w_acc;
            if (w_acc == ph_next_fwd(r_prev)) begin
              r_up <= bus.en;
            end else if (w_acc == ph_next_rev(r_prev)) begin
              r_down <= bus.en;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign bus.up    = r_up;
  assign bus.down  = r_down;
  assign bus.err   = r_err;
  assign bus.phase = r_prev;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder.
module tb_quad_decoder;

`ifdef QUAD_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif
  localparam int GAP = (LAT + 3 > 8) ? LAT + 3 : 8;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   cnt_up   = 0;
  int   cnt_down = 0;
  int   cnt_err  = 0;
  int   viol     = 0;
  int   s_up, s_down, s_err;

  quad_decoder_if bus ();

  quad_decoder #(.FILTER_LEN(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.up)   cnt_up++;
    if (bus.down) cnt_down++;
    if (bus.err)  cnt_err++;
    if (bus.up && bus.down) viol++;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    s_up = cnt_up; s_down = cnt_down; s_err = cnt_err;
  endtask

  // exp_pulse is {up,down,err} expected exactly LAT edges after the change.
  task automatic step(input logic a, input logic b, input logic [2:0] exp_pulse,
                      input string tag);
    @(negedge clk);
    bus.enc_a = a;
    bus.enc_b = b;
    repeat (LAT - 1) @(posedge clk);
    #1 chk({tag, " pre"}, {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    @(posedge clk);
    #1 chk({tag, " pulse"}, {5'b0, bus.up, bus.down, bus.err}, {5'b0, exp_pulse});
    chk({tag, " phase"}, {6'b0, bus.phase}, {6'b0, a, b});
    @(posedge clk);
    #1 chk({tag, " clr"}, {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    repeat (GAP - LAT - 1) @(posedge clk);
  endtask

  initial begin
    bus.enc_a = 1'b0;
    bus.enc_b = 1'b0;
    bus.en    = 1'b1;
    reset     = 1'b0;
    #2 reset  = 1'b1;
    #1 chk("rst outs", {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    chk("rst phase", {6'b0, bus.phase}, 8'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 chk("idle outs", {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    chk("idle phase", {6'b0, bus.phase}, 8'h0);

    snap();
    step(0, 1, 3'b100, "fwd01");
    step(1, 1, 3'b100, "fwd11");
    step(1, 0, 3'b100, "fwd10");
    step(0, 0, 3'b100, "fwd00");
    chk("fwd ups", 8'(cnt_up - s_up), 8'd4);
    chk("fwd downs", 8'(cnt_down - s_down), 8'd0);

    snap();
    step(1, 0, 3'b010, "rev10");
    step(1, 1, 3'b010, "rev11");
    step(0, 1, 3'b010, "rev01");
    step(0, 0, 3'b010, "rev00");
    chk("rev downs", 8'(cnt_down - s_down), 8'd4);
    chk("rev ups", 8'(cnt_up - s_up), 8'd0);

    step(1, 1, 3'b001, "jump11");
    step(1, 0, 3'b100, "after jump");
    step(0, 0, 3'b100, "back00");

    snap();
    bus.en = 1'b0;
    step(0, 1, 3'b000, "en0 01");
    step(1, 1, 3'b000, "en0 11");
    step(1, 0, 3'b000, "en0 10");
    step(0, 0, 3'b000, "en0 00");
    chk("en0 pulses", 8'((cnt_up - s_up) + (cnt_down - s_down) + (cnt_err - s_err)), 8'd0);
    bus.en = 1'b1;
    step(0, 1, 3'b100, "en1 01");
    step(0, 0, 3'b010, "en1 00");

`ifdef QUAD_FILTER_EN
    step(0, 1, 3'b100, "filt 01");
    snap();
    @(negedge clk);
    bus.enc_a = 1'b1;
    repeat (2) @(negedge clk);
    bus.enc_a = 1'b0;
    repeat (12) @(posedge clk);
    #1 chk("bounce pulses", 8'((cnt_up - s_up) + (cnt_down - s_down) + (cnt_err - s_err)), 8'd0);
    chk("bounce phase", {6'b0, bus.phase}, 8'h01);
    step(1, 1, 3'b100, "held 11");
    step(0, 1, 3'b010, "filt back01");
    step(0, 0, 3'b010, "filt back00");
`else
    // Three legal steps on consecutive cycles produce three adjacent pulses.
    @(negedge clk); bus.enc_b = 1'b1;
    @(negedge clk); bus.enc_a = 1'b1;
    @(negedge clk); bus.enc_b = 1'b0;
    @(posedge clk);
    #1 chk("burst1", {5'b0, bus.up, bus.down, bus.err, bus.phase}, {5'b0, 3'b100} << 2 | 8'h01);
    @(posedge clk);
    #1 chk("burst2", {5'b0, bus.up, bus.down, bus.err, bus.phase}, {5'b0, 3'b100} << 2 | 8'h03);
    @(posedge clk);
    #1 chk("burst3", {5'b0, bus.up, bus.down, bus.err, bus.phase}, {5'b0, 3'b100} << 2 | 8'h02);
    @(posedge clk);
    #1 chk("burst end", {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    repeat (GAP) @(posedge clk);
    step(0, 0, 3'b100, "burst back00");
`endif

    // Reset cuts an in-flight step; the new inputs are adopted silently.
    @(negedge clk);
    bus.enc_b = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1 chk("midrst phase", {6'b0, bus.phase}, 8'h0);
    chk("midrst outs", {5'b0, bus.up, bus.down, bus.err}, 8'h0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    snap();
    repeat (LAT + 6) @(posedge clk);
    #1 chk("postrst pulses", 8'((cnt_up - s_up) + (cnt_down - s_down) + (cnt_err - s_err)), 8'd0);
    chk("postrst phase", {6'b0, bus.phase}, 8'h01);
    step(1, 1, 3'b100, "postrst step");

    chk("up&down overlap", 8'(viol), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
